router_out_reader: RTL and testbench

- Read-side controller for one router output port. There are three instances, one per destination FIFO.
- Consumes `vld_out`/`soft_rst` from the router synchronizer and drives the FIFO `read_enb`.
- Pulls one complete packet per transaction: header, payload, parity. Presents the packet beat-by-beat to a downstream sink with start/end markers and a parity verdict.
- Aborts cleanly when the synchronizer soft-resets the FIFO.

---
 rtl/router_pkg.sv | 25 ++
 rtl/router_parity_acc.sv | 26 ++
 rtl/router_out_reader.sv | 144 ++++++++++++++
 tb/tb_router_out_reader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router output-port read side: the read FSM
// state type, header field positions and the length-field extractor.
package router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PLD,
    PAR,
    CHK
  } rd_state_t;

  localparam int LEN_MSB         = 7;
  localparam int LEN_LSB         = 2;
  localparam int ADDR_MSB        = 1;
  localparam int SOFT_RST_CYCLES = 30;
  localparam int MAX_PAYLOAD     = 63;
  localparam int WAIT_CNT_MAX    = 31;

  // Payload length L carried in the header byte.
  function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
    return hdr[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Byte-wise XOR parity accumulator. The header seeds it, payload bytes fold
// in, and match compares the running value against the parity byte on din.
module router_parity_acc #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              accumulate,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] acc,
  output logic              match
);

  // Accumulator register: clear beats load, load beats accumulate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           acc <= '0;
    else if (clear)      acc <= '0;
    else if (load)       acc <= din;
    else if (accumulate) acc <= acc ^ din;
  end

  assign match = (acc == din);

endmodule

// File: rtl/router_out_reader.sv
// Read-side controller for one router output port. Pulls one whole packet
// (header, L payload bytes, parity) from the destination FIFO, presents it
// beat by beat with start/end markers, and reports the parity verdict.
// A soft reset from the synchronizer drops the packet in flight.
module router_out_reader
  import router_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int WARN_THRESH = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  vld_out,
  input  logic                  soft_rst,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  rx_ready,
  output logic                  read_enb,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_sop,
  output logic                  rx_eop,
  output logic                  pkt_done,
  output logic                  parity_err,
  output logic                  pkt_abort,
  output logic                  stall_warn
);

  localparam logic [4:0] WARN_CNT = 5'(WARN_THRESH);
  localparam logic [4:0] SAT_CNT  = 5'(WAIT_CNT_MAX);

  rd_state_t       state, state_nxt;
  logic            rd_q, sop_q, eop_q;
  logic [5:0]      len;
  logic [6:0]      issued, limit;
  logic [4:0]      wait_cnt;
  logic            active, abort;
  logic            hdr_beat, pld_beat, par_beat;
  logic [DATA_WIDTH-1:0] acc;
  logic            acc_match;

  assign active   = (state != IDLE);
  assign abort    = soft_rst & active;
  assign hdr_beat = rd_q & sop_q & ~soft_rst;
  assign par_beat = rd_q & eop_q & ~soft_rst;
  assign pld_beat = rd_q & ~sop_q & ~eop_q & ~soft_rst;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; an abort from any busy state returns to IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (vld_out) state_nxt = HDR;
      HDR:  if (hdr_beat)
              state_nxt = (hdr_len(fifo_dout[LEN_MSB:0]) == 6'd0) ? PAR : PLD;
      PLD:  if (read_enb && (issued == {1'b0, len})) state_nxt = PAR;
      PAR:  if (read_enb) state_nxt = CHK;
      CHK:  if (par_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Read strobe: issue while the current phase still owes bytes. The limit
  // counts the header, so PLD stops at L+1 and PAR at L+2 reads.
  always_comb begin
    limit = 7'd0;
    unique case (state)
      HDR:     limit = 7'd1;
      PLD:     limit = {1'b0, len} + 7'd1;
      PAR:     limit = {1'b0, len} + 7'd2;
      default: limit = 7'd0;
    endcase
    read_enb = vld_out & rx_ready & ~soft_rst & (issued < limit);
  end

  // Beat tags and byte bookkeeping travelling one cycle behind read_enb.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q   <= 1'b0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
      issued <= '0;
      len    <= '0;
    end else begin
      rd_q  <= read_enb;
      sop_q <= read_enb & (state == HDR);
      eop_q <= read_enb & (state == PAR);
      if (abort) begin
        issued <= '0;
        len    <= '0;
      end else begin
        if (state == IDLE) issued <= '0;
        else if (read_enb) issued <= issued + 7'd1;
        if (hdr_beat) len <= hdr_len(fifo_dout[LEN_MSB:0]);
      end
    end
  end

  // Completion, parity verdict and abort pulses, one cycle after the cause.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      pkt_abort  <= 1'b0;
    end else begin
      pkt_done   <= par_beat;
      parity_err <= par_beat & ~acc_match;
      pkt_abort  <= abort;
    end
  end

  // Starvation counter: data waiting but no read going out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                wait_cnt <= '0;
    else if (soft_rst || !vld_out || read_enb) wait_cnt <= '0;
    else if (wait_cnt != SAT_CNT)             wait_cnt <= wait_cnt + 5'd1;
  end

  assign stall_warn = (wait_cnt >= WARN_CNT);

  router_parity_acc #(
    .DATA_W(DATA_WIDTH)
  ) u_parity (
    .clock      (clock),
    .reset      (reset),
    .clear      (abort),
    .load       (hdr_beat),
    .accumulate (pld_beat),
    .din        (fifo_dout),
    .acc        (acc),
    .match      (acc_match)
  );

  assign rx_valid = rd_q & ~soft_rst;
  assign rx_sop   = rx_valid & sop_q;
  assign rx_eop   = rx_valid & eop_q;
  assign rx_data  = rx_valid ? fifo_dout : '0;

endmodule

// File: tb/tb_router_out_reader.sv
// Bench for router_out_reader: a FIFO model feeds the reader, expected beats
// go into a scoreboard queue as packets are loaded and are popped as beats
// appear. A packet table covers the main cases; hand sequences cover gaps,
// starvation/soft reset and an asynchronous reset mid-packet.
module tb_router_out_reader;

  logic       clock = 1'b0;
  logic       reset;
  logic       vld_out;
  logic       soft_rst;
  logic [7:0] fifo_dout;
  logic       rx_ready;
  logic       read_enb;
  logic [7:0] rx_data;
  logic       rx_valid, rx_sop, rx_eop;
  logic       pkt_done, parity_err, pkt_abort, stall_warn;

  router_out_reader #(.DATA_WIDTH(8), .WARN_THRESH(24)) dut (
    .clock      (clock),
    .reset      (reset),
    .vld_out    (vld_out),
    .soft_rst   (soft_rst),
    .fifo_dout  (fifo_dout),
    .rx_ready   (rx_ready),
    .read_enb   (read_enb),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_sop     (rx_sop),
    .rx_eop     (rx_eop),
    .pkt_done   (pkt_done),
    .parity_err (parity_err),
    .pkt_abort  (pkt_abort),
    .stall_warn (stall_warn)
  );

  always #5 clock = ~clock;

  // FIFO model: written by the stimulus, read by the DUT strobe.
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr;
  logic       vld_en;
  int         rd_count = 0;
  int         viol = 0;

  assign vld_out = vld_en && (wr_ptr != rd_ptr);

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr    <= wr_ptr;
      fifo_dout <= 8'h00;
    end else if (soft_rst) begin
      rd_ptr <= wr_ptr;
    end else if (read_enb) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
      rd_count  <= rd_count + 1;
    end
    if (!reset && read_enb && (!vld_out || !rx_ready || soft_rst)) viol <= viol + 1;
  end

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
  } beat_t;

  typedef struct {
    logic [7:0]  hdr;
    logic [63:0] pay;   // payload byte i at pay[8*i +: 8]
    logic [7:0]  par;
    logic        exp_err;
  } vec_t;

  beat_t exp_q[$];
  vec_t  tbl[4];
  int    total = 0;
  int    bad = 0;
  int    done_cnt = 0, err_cnt = 0, abort_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and check whatever the DUT produced.
  task automatic tick();
    beat_t e;
    @(negedge clock);
    if (rx_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_beat actual=%0h required=none", rx_data);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", 32'(rx_data), 32'(e.d));
        chk("beat_sop", 32'(rx_sop), 32'(e.s));
        chk("beat_eop", 32'(rx_eop), 32'(e.e));
      end
    end
    if (parity_err) chk("err_with_done", 32'(pkt_done), 32'd1);
    if (pkt_done)   done_cnt++;
    if (parity_err) err_cnt++;
    if (pkt_abort)  abort_cnt++;
  endtask

  task automatic load_pkt(input logic [7:0] hdr, input logic [63:0] pay, input logic [7:0] par);
    int l;
    l = int'(hdr[7:2]);
    mem[wr_ptr] = hdr;
    wr_ptr = wr_ptr + 8'd1;
    exp_q.push_back('{d: hdr, s: 1'b1, e: 1'b0});
    for (int i = 0; i < l; i++) begin
      mem[wr_ptr] = pay[8*i +: 8];
      wr_ptr = wr_ptr + 8'd1;
      exp_q.push_back('{d: pay[8*i +: 8], s: 1'b0, e: 1'b0});
    end
    mem[wr_ptr] = par;
    wr_ptr = wr_ptr + 8'd1;
    exp_q.push_back('{d: par, s: 1'b0, e: 1'b1});
  endtask

  task automatic wait_reads(input int r0, input int n, input string name);
    for (int c = 0; c < 100 && (rd_count - r0) < n; c++) tick();
    chk(name, 32'(rd_count - r0), 32'(n));
  endtask

  task automatic finish_pkt(input int r0, input int d0, input int e0, input int nbytes,
                            input logic exp_err, input string name);
    for (int c = 0; c < 200 && done_cnt == d0; c++) tick();
    chk({name, "_done"}, 32'(done_cnt - d0), 32'd1);
    chk({name, "_err"}, 32'(err_cnt - e0), 32'(exp_err));
    chk({name, "_reads"}, 32'(rd_count - r0), 32'(nbytes));
    chk({name, "_beats_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_strobe_viol"}, 32'(viol), 32'd0);
  endtask

  task automatic run_vec(input int idx);
    int r0, d0, e0;
    r0 = rd_count; d0 = done_cnt; e0 = err_cnt;
    load_pkt(tbl[idx].hdr, tbl[idx].pay, tbl[idx].par);
    vld_en = 1'b1;
    rx_ready = 1'b1;
    finish_pkt(r0, d0, e0, int'(tbl[idx].hdr[7:2]) + 2, tbl[idx].exp_err, $sformatf("vec%0d", idx));
    tick();
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_read_enb"}, 32'(read_enb), 32'd0);
    chk({name, "_rx_valid"}, 32'(rx_valid), 32'd0);
    chk({name, "_rx_data"}, 32'(rx_data), 32'd0);
    chk({name, "_sop_eop"}, 32'({rx_sop, rx_eop}), 32'd0);
    chk({name, "_pulses"}, 32'({pkt_done, parity_err, pkt_abort}), 32'd0);
    chk({name, "_stall_warn"}, 32'(stall_warn), 32'd0);
  endtask

  initial begin
    int r0, d0, e0, a0;
    // 0x0E ^ 0x11 ^ 0x22 ^ 0x33 = 0x0E
    tbl[0] = '{8'h0E, 64'h0000_0000_0033_2211, 8'h0E, 1'b0};
    tbl[1] = '{8'h0E, 64'h0000_0000_0033_2211, 8'h0B, 1'b1};
    tbl[2] = '{8'h01, 64'h0,                   8'h01, 1'b0};
    // 0x12 ^ 0xA5 ^ 0x5A ^ 0xFF ^ 0x00 = 0x12
    tbl[3] = '{8'h12, 64'h0000_0000_00FF_5AA5, 8'h12, 1'b0};

    reset = 1'b1; soft_rst = 1'b0; rx_ready = 1'b0; vld_en = 1'b0;
    repeat (2) @(negedge clock);
    chk_zero("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_vec(i);

    // FIFO runs dry after payload byte 1, then the sink back-pressures.
    r0 = rd_count; d0 = done_cnt; e0 = err_cnt;
    load_pkt(8'h0E, 64'h332211, 8'h0E);
    vld_en = 1'b1; rx_ready = 1'b1;
    wait_reads(r0, 2, "gap_start");
    vld_en = 1'b0;
    repeat (4) tick();
    chk("gap_vld_hold", 32'(rd_count - r0), 32'd2);
    vld_en = 1'b1;
    tick();
    rx_ready = 1'b0;
    repeat (3) tick();
    chk("gap_rdy_hold", 32'(rd_count - r0), 32'd3);
    rx_ready = 1'b1;
    finish_pkt(r0, d0, e0, 5, 1'b0, "gap");
    tick();

    // Starvation in PLD, then soft reset with a beat in flight.
    r0 = rd_count; d0 = done_cnt;
    load_pkt(8'h14, 64'h05_0403_0201, 8'h15);
    vld_en = 1'b1; rx_ready = 1'b1;
    wait_reads(r0, 2, "stall_start");
    rx_ready = 1'b0;
    repeat (23) tick();
    chk("warn_23", 32'(stall_warn), 32'd0);
    tick();
    chk("warn_24", 32'(stall_warn), 32'd1);
    rx_ready = 1'b1;
    tick();
    chk("stall_resume_read", 32'(rd_count - r0), 32'd3);
    soft_rst = 1'b1; rx_ready = 1'b0;
    #1;
    chk("abort_suppress", 32'(rx_valid), 32'd0);
    chk("abort_no_read", 32'(read_enb), 32'd0);
    exp_q.delete();
    a0 = abort_cnt;
    tick();
    soft_rst = 1'b0;
    tick();
    chk("abort_pulse", 32'(abort_cnt - a0), 32'd1);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_warn_clear", 32'(stall_warn), 32'd0);
    // Soft reset while idle must not pulse.
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    tick();
    chk("idle_soft_rst", 32'(abort_cnt - a0), 32'd1);
    run_vec(0);

    // Asynchronous reset between edges mid-payload.
    r0 = rd_count;
    load_pkt(8'h0E, 64'h332211, 8'h0E);
    vld_en = 1'b1; rx_ready = 1'b1;
    wait_reads(r0, 3, "areset_start");
    #2 reset = 1'b1;
    #1 chk_zero("areset");
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
    run_vec(0);
    run_vec(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
